// File: rtl/inner_mem_controller_if.sv
// Load/store handshake between the pipeline MEM stage (master) and the
// memory controller (slave).
// Optional feature macro: MISALIGN_TRAP_EN adds the misaligned flag.
interface inner_memory_if;
   logic        mem_req;
   logic        MemRW;
   logic [2:0]  RWType;
   logic [31:0] addr_out;
   logic [31:0] data_out;
   logic [31:0] data_in;
   logic        stall;
   logic        done;
`ifdef MISALIGN_TRAP_EN
   logic        misaligned;

   modport master (output mem_req, MemRW, RWType, addr_out, data_out,
                   input  data_in, stall, done, misaligned);
   modport slave  (input  mem_req, MemRW, RWType, addr_out, data_out,
                   output data_in, stall, done, misaligned);
`else
   modport master (output mem_req, MemRW, RWType, addr_out, data_out,
                   input  data_in, stall, done);
   modport slave  (input  mem_req, MemRW, RWType, addr_out, data_out,
                   output data_in, stall, done);
`endif
endinterface

// File: rtl/inner_mem_controller.sv
// Memory controller: serves pipeline loads/stores against a word-wide
// synchronous RAM. Sub-word loads are extended, sub-word stores are done
// as read-modify-write, and the pipeline is stalled until completion.
// Optional feature macro: MISALIGN_TRAP_EN (flags and suppresses
// misaligned H/HU/W accesses).
module inner_mem_controller #(
   parameter int RAM_AW = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   inner_memory_if.slave     bus,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4
   } state_t;

   localparam logic [2:0] T_B  = 3'b000;
   localparam logic [2:0] T_H  = 3'b001;
   localparam logic [2:0] T_W  = 3'b010;
   localparam logic [2:0] T_BU = 3'b100;
   localparam logic [2:0] T_HU = 3'b101;

   state_t            state;
   logic [2:0]        type_r;
   logic [RAM_AW+1:0] addr_r;
   logic [31:0]       data_r;
   logic [31:0]       data_in_r;
   logic              done_r;
   logic              stall_s;
`ifdef MISALIGN_TRAP_EN
   logic              mis_r;
   logic              mis_out_r;
`endif

   // Extract and extend the addressed lane of a RAM word for a load.
   function automatic logic [31:0] fmt_load(input logic [2:0]  t,
                                            input logic [1:0]  a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (t)
         T_B:     fmt_load = {{24{b[7]}}, b};
         T_H:     fmt_load = {{16{h[15]}}, h};
         T_W:     fmt_load = w;
         T_BU:    fmt_load = {24'd0, b};
         T_HU:    fmt_load = {16'd0, h};
         default: fmt_load = 32'd0;
      endcase
   endfunction

   // Replace the addressed byte/half of the old word with store data.
   function automatic logic [31:0] merge_store(input logic [2:0]  t,
                                               input logic [1:0]  a,
                                               input logic [31:0] old,
                                               input logic [31:0] d);
      logic [31:0] w;
      w = old;
      case (t)
         T_B: begin
            case (a)
               2'd0:    w[7:0]   = d[7:0];
               2'd1:    w[15:8]  = d[7:0];
               2'd2:    w[23:16] = d[7:0];
               default: w[31:24] = d[7:0];
            endcase
         end
         T_H: begin
            if (a[1]) w[31:16] = d[15:0];
            else      w[15:0]  = d[15:0];
         end
         default: w = old;
      endcase
      return w;
   endfunction

`ifdef MISALIGN_TRAP_EN
   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] t,
                                          input logic [1:0] a);
      case (t)
         T_H, T_HU: is_misaligned = a[0];
         T_W:       is_misaligned = (a != 2'b00);
         default:   is_misaligned = 1'b0;
      endcase
   endfunction
`endif

   // Access sequencer: latches the request, steps through the RAM cycles
   // and produces the registered RAM strobes, load result and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         type_r    <= 3'd0;
         addr_r    <= '0;
         data_r    <= 32'd0;
         data_in_r <= 32'd0;
         done_r    <= 1'b0;
         ram_we    <= 1'b0;
         ram_wdata <= 32'd0;
`ifdef MISALIGN_TRAP_EN
         mis_r     <= 1'b0;
         mis_out_r <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         ram_we <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         mis_out_r <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.mem_req) begin
                  type_r <= bus.RWType;
                  addr_r <= bus.addr_out[RAM_AW+1:0];
                  data_r <= bus.data_out;
`ifdef MISALIGN_TRAP_EN
                  mis_r  <= is_misaligned(bus.RWType, bus.addr_out[1:0]);
`endif
                  if (!bus.MemRW) begin
                     // Load: RAM samples the address this edge.
                     state  <= RD;
                     done_r <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                     mis_out_r <= is_misaligned(bus.RWType, bus.addr_out[1:0]);
`endif
                  end else if (bus.RWType == T_B || bus.RWType == T_H) begin
                     state <= RMW_RD;
                  end else begin
                     // Full-word or illegal store: single write cycle,
                     // the strobe is only raised for a legal W.
                     state     <= WR;
                     done_r    <= 1'b1;
                     ram_wdata <= bus.data_out;
`ifdef MISALIGN_TRAP_EN
                     ram_we    <= (bus.RWType == T_W) &&
                                  !is_misaligned(bus.RWType, bus.addr_out[1:0]);
                     mis_out_r <= is_misaligned(bus.RWType, bus.addr_out[1:0]);
`else
                     ram_we    <= (bus.RWType == T_W);
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RD: begin
`ifdef MISALIGN_TRAP_EN
               if (!mis_r) data_in_r <= fmt_load(type_r, addr_r[1:0], ram_rdata);
               else        data_in_r <= data_in_r;
`else
               data_in_r <= fmt_load(type_r, addr_r[1:0], ram_rdata);
`endif
               state <= IDLE;
            end
            WR: begin
               state <= IDLE;
            end
            RMW_RD: begin
               ram_wdata <= merge_store(type_r, addr_r[1:0], ram_rdata, data_r);
               done_r    <= 1'b1;
`ifdef MISALIGN_TRAP_EN
               ram_we    <= !mis_r;
               mis_out_r <= mis_r;
`else
               ram_we    <= 1'b1;
`endif
               state     <= RMW_WR;
            end
            RMW_WR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM address: follow the bus in the accept cycle so the synchronous
   // RAM returns data during the next state, otherwise hold the latch.
   always_comb begin
      ram_addr = addr_r[RAM_AW+1:2];
      if (state == IDLE && bus.mem_req) ram_addr = bus.addr_out[RAM_AW+1:2];
      else                              ram_addr = addr_r[RAM_AW+1:2];
   end

   // Pipeline hold: asserted from accept until the completion cycle.
   always_comb begin
      stall_s = 1'b0;
      if (state == IDLE) stall_s = bus.mem_req;
      else               stall_s = ~done_r;
   end

   assign bus.stall   = stall_s;
   assign bus.done    = done_r;
   assign bus.data_in = data_in_r;
`ifdef MISALIGN_TRAP_EN
   assign bus.misaligned = mis_out_r;
`endif

endmodule

// File: tb/tb_inner_mem_controller.sv
// Directed self-checking bench for inner_mem_controller with a
// behavioural synchronous RAM model.
module tb_inner_mem_controller;
   localparam int RAM_AW = 10;

   logic              clk;
   logic              rst_n;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [31:0]       mem [0:(1<<RAM_AW)-1];

   int checks = 0;
   int passes = 0;

   inner_memory_if bus ();

   inner_mem_controller #(.RAM_AW(RAM_AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: one-cycle read latency, full-word write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Access results
   int          lat, stalls;
   logic        we_seen, mis_seen;
   logic [31:0] wr_addr, wr_data;

   // Called just after a posedge; returns just after the posedge that
   // ends the done cycle with mem_req dropped.
   task automatic access(input logic rw, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d);
      logic got;
      bus.mem_req  = 1'b1;
      bus.MemRW    = rw;
      bus.RWType   = t;
      bus.addr_out = a;
      bus.data_out = d;
      lat = 0; stalls = 0; we_seen = 1'b0; mis_seen = 1'b0; got = 1'b0;
      wr_addr = 32'd0; wr_data = 32'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         lat++;
         if (bus.stall) stalls++;
         if (ram_we) begin
            we_seen = 1'b1;
            wr_addr = {22'd0, ram_addr};
            wr_data = ram_wdata;
         end
`ifdef MISALIGN_TRAP_EN
         if (bus.done) mis_seen = bus.misaligned;
`endif
         if (bus.done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("access_timeout", {31'd0, got}, 32'd1);
      @(posedge clk);
      #1;
      bus.mem_req = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.mem_req  = 1'b0;
      bus.MemRW    = 1'b0;
      bus.RWType   = 3'b000;
      bus.addr_out = 32'd0;
      bus.data_out = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_data_in", bus.data_in, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr", {22'd0, ram_addr}, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // SW then LW of the same word
      access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      chk("sw_lat", lat, 32'd2);
      chk("sw_we", {31'd0, we_seen}, 32'd1);
      chk("sw_addr", wr_addr, 32'd4);
      chk("sw_wdata", wr_data, 32'hDEADBEEF);
      chk("sw_mem", mem[4], 32'hDEADBEEF);
      access(1'b0, 3'b010, 32'h10, 32'd0);
      chk("lw_lat", lat, 32'd2);
      chk("lw_stalls", stalls, 32'd1);
      chk("lw_data", bus.data_in, 32'hDEADBEEF);

      // SB read-modify-write
      access(1'b1, 3'b010, 32'h10, 32'h11223344);
      access(1'b1, 3'b000, 32'h12, 32'h000000AB);
      chk("sb_lat", lat, 32'd3);
      chk("sb_stalls", stalls, 32'd2);
      chk("sb_mem", mem[4], 32'h11AB3344);
      chk("sb_data_in_hold", bus.data_in, 32'hDEADBEEF);

      // Sub-word load formatting
      access(1'b1, 3'b010, 32'h10, 32'h8000FF7F);
      access(1'b0, 3'b000, 32'h11, 32'd0);
      chk("lb_11", bus.data_in, 32'hFFFFFFFF);
      access(1'b0, 3'b100, 32'h11, 32'd0);
      chk("lbu_11", bus.data_in, 32'h000000FF);
      access(1'b0, 3'b001, 32'h12, 32'd0);
      chk("lh_12", bus.data_in, 32'hFFFF8000);
      access(1'b0, 3'b101, 32'h12, 32'd0);
      chk("lhu_12", bus.data_in, 32'h00008000);
      access(1'b0, 3'b000, 32'h10, 32'd0);
      chk("lb_10", bus.data_in, 32'h0000007F);
`ifndef MISALIGN_TRAP_EN
      access(1'b0, 3'b001, 32'h13, 32'd0);
      chk("lh_13_odd", bus.data_in, 32'hFFFF8000);
`endif
      // Address wrap: bit 12 lies above the RAM word address
      access(1'b0, 3'b010, 32'h1010, 32'd0);
      chk("lw_wrap", bus.data_in, 32'h8000FF7F);

      // Illegal load type
      access(1'b0, 3'b011, 32'h10, 32'd0);
      chk("ill_ld_lat", lat, 32'd2);
      chk("ill_ld_data", bus.data_in, 32'd0);

      // Back-to-back SH then LW
      access(1'b1, 3'b010, 32'h14, 32'hCAFEF00D);
      access(1'b1, 3'b001, 32'h16, 32'h00001234);
      chk("sh_lat", lat, 32'd3);
      access(1'b0, 3'b010, 32'h14, 32'd0);
      chk("b2b_lat", lat, 32'd2);
      chk("b2b_data", bus.data_in, 32'h1234F00D);

      // Illegal store type
      access(1'b1, 3'b111, 32'h10, 32'h55555555);
      chk("ill_st_lat", lat, 32'd2);
      chk("ill_st_we", {31'd0, we_seen}, 32'd0);
      chk("ill_st_mem", mem[4], 32'h8000FF7F);

      // Reset during RMW_RD
      bus.mem_req  = 1'b1;
      bus.MemRW    = 1'b1;
      bus.RWType   = 3'b000;
      bus.addr_out = 32'h10;
      bus.data_out = 32'h00000055;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      bus.mem_req = 1'b0;
      #1;
      chk("midrst_we", {31'd0, ram_we}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_data_in", bus.data_in, 32'd0);
      chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_mem", mem[4], 32'h8000FF7F);

`ifdef MISALIGN_TRAP_EN
      access(1'b0, 3'b010, 32'h10, 32'd0);
      chk("mis_pre", {31'd0, mis_seen}, 32'd0);
      access(1'b0, 3'b010, 32'h13, 32'd0);
      chk("mis_lw_flag", {31'd0, mis_seen}, 32'd1);
      chk("mis_lw_lat", lat, 32'd2);
      chk("mis_lw_data", bus.data_in, 32'h8000FF7F);
      access(1'b1, 3'b001, 32'h11, 32'h0000AAAA);
      chk("mis_sh_flag", {31'd0, mis_seen}, 32'd1);
      chk("mis_sh_we", {31'd0, we_seen}, 32'd0);
      chk("mis_sh_mem", mem[4], 32'h8000FF7F);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
